// File: rtl/ustc_dn_pipe.sv
// Two-stage handshaked distribution network: A broadcast across the N stack, B rows gathered by per-line index.
// Optional sticky out-of-range index flag is built when USTC_DN_IDX_CHECK_EN is defined.
module ustc_dn_pipe #(
    parameter int TILE_M  = 4,
    parameter int TILE_K  = 8,
    parameter int TILE_N  = 4,
    parameter int K_B     = 16,
    parameter int DW_DATA = 8,
    parameter int DW_IDX  = 4,
    parameter int CNT_W   = 16,
    parameter int N_LINE  = TILE_M * TILE_K,
    parameter int DW_LINE = DW_DATA * TILE_N
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_LINE*DW_DATA-1:0]   in_a,
    input  logic [K_B*DW_LINE-1:0]      in_b,
    input  logic [N_LINE*DW_IDX-1:0]    idx,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N_LINE*DW_LINE-1:0]   out_a,
    output logic [N_LINE*DW_LINE-1:0]   out_b,
    output logic [CNT_W-1:0]            tile_cnt,
    output logic                        err_idx
);

    logic                        s1_valid;
    logic [N_LINE*DW_DATA-1:0]   s1_a;
    logic [K_B*DW_LINE-1:0]      s1_b;
    logic [N_LINE*DW_IDX-1:0]    s1_idx;
    logic                        s2_valid;
    logic                        s1_load;
    logic                        s2_load;
    logic [N_LINE*DW_LINE-1:0]   a_line_next;
    logic [N_LINE*DW_LINE-1:0]   b_line_next;
    logic [N_LINE-1:0]           oob;

    assign s2_load   = !s2_valid || out_ready;
    assign in_ready  = !reset && (!s1_valid || s2_load);
    assign s1_load   = in_valid && in_ready;
    assign out_valid = s2_valid;

    genvar gi;
    generate
        for (gi = 0; gi < N_LINE; gi++) begin : g_line
            logic [DW_LINE-1:0] b_sel;
            logic               miss;

            assign a_line_next[gi*DW_LINE +: DW_LINE] = {TILE_N{s1_a[gi*DW_DATA +: DW_DATA]}};

            // Full compare against every legal row: indices >= K_B match nothing and yield zero.
            always_comb begin
                b_sel = '0;
                miss  = 1'b1;
                for (int r = 0; r < K_B; r++) begin
                    if (s1_idx[gi*DW_IDX +: DW_IDX] == DW_IDX'(r)) begin
                        b_sel = s1_b[r*DW_LINE +: DW_LINE];
                        miss  = 1'b0;
                    end
                end
            end

            assign b_line_next[gi*DW_LINE +: DW_LINE] = b_sel;
            assign oob[gi] = miss;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_idx   <= '0;
            s2_valid <= 1'b0;
            out_a    <= '0;
            out_b    <= '0;
            tile_cnt <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_a     <= in_a;
                s1_b     <= in_b;
                s1_idx   <= idx;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_a <= a_line_next;
                    out_b <= b_line_next;
                end
            end
            if (s2_valid && out_ready) begin
                tile_cnt <= tile_cnt + 1'b1;
            end
        end
    end

`ifdef USTC_DN_IDX_CHECK_EN
    logic err_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else if (s2_load && s1_valid && (|oob)) begin
            err_reg <= 1'b1;
        end
    end

    assign err_idx = err_reg;
`else
    logic unused_oob;
    assign unused_oob = ^oob;
    assign err_idx    = 1'b0;
`endif

endmodule

// File: tb/tb_ustc_dn_pipe.sv
// Directed bench for ustc_dn_pipe (K_B=12, CNT_W=4): latency, backpressure hold, out-of-range index,
// counter wrap, mid-stream async reset and a random-handshake scoreboard run.
module tb_ustc_dn_pipe;

    localparam int NL  = 32;
    localparam int DWL = 32;
    localparam int KB  = 12;
    localparam int CW  = 4;
`ifdef USTC_DN_IDX_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [NL*8-1:0]      in_a;
    logic [KB*DWL-1:0]    in_b;
    logic [NL*4-1:0]      idx;
    logic                 out_valid;
    logic                 out_ready;
    logic [NL*DWL-1:0]    out_a;
    logic [NL*DWL-1:0]    out_b;
    logic [CW-1:0]        tile_cnt;
    logic                 err_idx;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] q_tag[$];
    logic       q_oob[$];
    logic [CW-1:0] cnt_model = '0;
    logic last_ov, last_ir, acc;
    logic [NL*DWL-1:0] snap_a, snap_b;
    logic [7:0] nt;

    ustc_dn_pipe #(.K_B(KB), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .idx(idx),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b),
        .tile_cnt(tile_cnt), .err_idx(err_idx)
    );

    always #10 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_tile(input logic [7:0] tag, input logic oob);
        for (int l = 0; l < NL; l++) begin
            in_a[l*8 +: 8] = 8'(l + 1) + tag;
            idx[l*4 +: 4]  = (oob && l == 5) ? 4'd15 : 4'(l % KB);
        end
        for (int r = 0; r < KB; r++)
            in_b[r*DWL +: DWL] = {4{8'(r) + {tag[3:0], 4'h0}}};
    endtask

    task automatic check_tile(input logic [7:0] tag, input logic oob);
        logic [31:0] ea, eb;
        for (int l = 0; l < NL; l++) begin
            ea = {4{8'(l + 1) + tag}};
            eb = (oob && l == 5) ? 32'h0 : {4{8'(l % KB) + {tag[3:0], 4'h0}}};
            check($sformatf("out_a[%0d] tile %0d", l, tag), 64'(out_a[l*DWL +: DWL]), 64'(ea));
            check($sformatf("out_b[%0d] tile %0d", l, tag), 64'(out_b[l*DWL +: DWL]), 64'(eb));
        end
    endtask

    // One clock cycle: drive, sample at the falling edge, score handshakes, then move past the rising edge.
    task automatic step(input logic v, input logic [7:0] tag, input logic oob, input logic ordy,
                        output logic accepted);
        in_valid  = v;
        out_ready = ordy;
        load_tile(tag, oob);
        @(negedge clk);
        last_ov  = out_valid;
        last_ir  = in_ready;
        accepted = v && in_ready;
        if (out_valid && out_ready) begin
            if (q_tag.size() == 0) begin
                check("unexpected_out", 64'd1, 64'd0);
            end else begin
                check_tile(q_tag[0], q_oob[0]);
                void'(q_tag.pop_front());
                void'(q_oob.pop_front());
            end
            cnt_model = cnt_model + 1'b1;
        end
        if (accepted) begin
            q_tag.push_back(tag);
            q_oob.push_back(oob);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic a;
        for (int c = 0; c < 8; c++) step(1'b0, 8'd0, 1'b0, 1'b1, a);
        check("drain_empty", 64'(q_tag.size()), 64'd0);
        check("tile_cnt_model", 64'(tile_cnt), 64'(cnt_model));
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        load_tile(8'd0, 1'b0);
        #3;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_a_zero", 64'(out_a == '0), 64'd1);
        check("rst_out_b_zero", 64'(out_b == '0), 64'd1);
        check("rst_tile_cnt", 64'(tile_cnt), 64'd0);
        check("rst_err_idx", 64'(err_idx), 64'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1 check("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Four back-to-back tiles, out_ready high.
        step(1'b1, 8'd0, 1'b0, 1'b1, acc); check("lat_ov0", 64'(last_ov), 64'd0);
        step(1'b1, 8'd1, 1'b0, 1'b1, acc); check("lat_ov1", 64'(last_ov), 64'd0);
        step(1'b1, 8'd2, 1'b0, 1'b1, acc); check("lat_ov2", 64'(last_ov), 64'd1);
        step(1'b1, 8'd3, 1'b0, 1'b1, acc); check("lat_ov3", 64'(last_ov), 64'd1);
        step(1'b0, 8'd0, 1'b0, 1'b1, acc); check("lat_ov4", 64'(last_ov), 64'd1);
        step(1'b0, 8'd0, 1'b0, 1'b1, acc); check("lat_ov5", 64'(last_ov), 64'd1);
        step(1'b0, 8'd0, 1'b0, 1'b1, acc); check("bubble_ov6", 64'(last_ov), 64'd0);
        check("stream_tile_cnt", 64'(tile_cnt), 64'd4);
        drain();

        // Backpressure for three cycles.
        step(1'b1, 8'd10, 1'b0, 1'b1, acc); check("gap_acc10", 64'(acc), 64'd1);
        step(1'b1, 8'd11, 1'b0, 1'b0, acc); check("gap_acc11", 64'(acc), 64'd1);
        snap_a = out_a;
        snap_b = out_b;
        step(1'b1, 8'd12, 1'b0, 1'b0, acc); check("gap_acc12_blocked", 64'(acc), 64'd0);
        check("gap_in_ready_low1", 64'(last_ir), 64'd0);
        check("gap_hold_a1", 64'(out_a == snap_a), 64'd1);
        check("gap_hold_b1", 64'(out_b == snap_b), 64'd1);
        step(1'b1, 8'd12, 1'b0, 1'b0, acc); check("gap_in_ready_low2", 64'(last_ir), 64'd0);
        check("gap_hold_a2", 64'(out_a == snap_a), 64'd1);
        check("gap_hold_b2", 64'(out_b == snap_b), 64'd1);
        check("gap_hold_ov", 64'(out_valid), 64'd1);
        step(1'b1, 8'd12, 1'b0, 1'b1, acc); check("gap_acc12", 64'(acc), 64'd1);
        drain();
        check("gap_tile_cnt", 64'(tile_cnt), 64'd7);

        // Out-of-range index on line 5, then clean tiles: flag must stay set.
        step(1'b1, 8'd20, 1'b1, 1'b1, acc);
        step(1'b1, 8'd21, 1'b0, 1'b1, acc);
        drain();
        check("err_idx_set", 64'(err_idx), 64'(ERR_EXP));
        step(1'b1, 8'd22, 1'b0, 1'b1, acc);
        drain();
        check("err_idx_sticky", 64'(err_idx), 64'(ERR_EXP));

        // Fill both stages, then reset asynchronously between edges.
        step(1'b1, 8'd30, 1'b0, 1'b0, acc);
        step(1'b1, 8'd31, 1'b0, 1'b0, acc);
        check("full_in_ready_low", 64'(in_ready), 64'd0);
        #2 reset = 1'b1;
        #2;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_a_zero", 64'(out_a == '0), 64'd1);
        check("mid_rst_out_b_zero", 64'(out_b == '0), 64'd1);
        check("mid_rst_tile_cnt", 64'(tile_cnt), 64'd0);
        check("mid_rst_err_idx", 64'(err_idx), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        #2 reset = 1'b0;
        q_tag.delete();
        q_oob.delete();
        cnt_model = '0;

        // 17 tiles after reset: latency re-checked, counter wraps to 1.
        step(1'b1, 8'd40, 1'b0, 1'b1, acc); check("post_rst_in_ready", 64'(last_ir), 64'd1);
        check("post_rst_ov0", 64'(last_ov), 64'd0);
        step(1'b1, 8'd41, 1'b0, 1'b1, acc); check("post_rst_ov1", 64'(last_ov), 64'd0);
        step(1'b1, 8'd42, 1'b0, 1'b1, acc); check("post_rst_ov2", 64'(last_ov), 64'd1);
        for (int t = 43; t < 57; t++) step(1'b1, 8'(t), 1'b0, 1'b1, acc);
        drain();
        check("wrap_tile_cnt", 64'(tile_cnt), 64'd1);
        check("post_rst_err_idx", 64'(err_idx), 64'd0);

        // Random valid/ready traffic against the scoreboard.
        nt = 8'd60;
        for (int c = 0; c < 1000; c++) begin
            step(1'($urandom_range(0, 1)), nt, (nt % 7) == 0, $urandom_range(0, 3) != 0, acc);
            if (acc) nt = nt + 1'b1;
        end
        drain();
        check("rand_err_idx", 64'(err_idx), 64'(ERR_EXP));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
